// File: rtl/v11_pulse_emulator.sv
// Detector-preamp emulator: baseline plus linear-rise / exponential-tail pulses, output combinational from registers (0 clk latency).
// Triggers use valid/ready; ready drops only while rising or when disabled, and a trigger during the tail piles onto the residual level.
module v11_pulse_emulator #(
    parameter int SIZE_ADC_DATA = 12,
    parameter int BASELINE      = 100,
    parameter int DECAY_SHIFT   = 4,
    parameter int RISE_SHIFT    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     trig_valid,
    input  logic [SIZE_ADC_DATA-1:0] trig_amp,
    output logic                     trig_ready,
    output logic [SIZE_ADC_DATA-1:0] output_data,
    output logic                     busy,
    output logic                     sat,
    output logic [15:0]              pulse_count
);

    localparam int LW = SIZE_ADC_DATA + DECAY_SHIFT + 1;
    localparam int CW = RISE_SHIFT + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RISE  = 2'd1;
    localparam logic [1:0] ST_DECAY = 2'd2;

    localparam logic [LW:0]   ADC_MAX_EXT = {{(LW + 1 - SIZE_ADC_DATA){1'b0}}, {SIZE_ADC_DATA{1'b1}}};
    localparam logic [LW:0]   LVL_MAX     = ADC_MAX_EXT << DECAY_SHIFT;
    localparam logic [CW-1:0] LAST_STEP   = {CW{1'b1}} >> 1;
    localparam logic [31:0]   ADC_MAX     = 32'((1 << SIZE_ADC_DATA) - 1);

    if (RISE_SHIFT > DECAY_SHIFT) begin : g_bad_shift
        $error("RISE_SHIFT must not exceed DECAY_SHIFT");
    end

    logic [1:0]               state_q, state_d;
    logic [LW-1:0]            lvl_q, lvl_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [SIZE_ADC_DATA-1:0] amp_q, amp_d;
    logic [15:0]              pcnt_q, pcnt_d;

    logic [LW-1:0] step;
    logic [LW:0]   rise_sum;
    logic [LW-1:0] decay_amt;
    logic [31:0]   out_sum;
    logic          accept;

    // Rise is split into 2^RISE_SHIFT equal steps summing to amp << DECAY_SHIFT.
    assign step      = {{(LW - SIZE_ADC_DATA){1'b0}}, amp_q} << (DECAY_SHIFT - RISE_SHIFT);
    assign rise_sum  = {1'b0, lvl_q} + {1'b0, step};
    assign decay_amt = lvl_q >> DECAY_SHIFT;

    assign trig_ready = enable && (state_q != ST_RISE);
    assign accept     = trig_valid && trig_ready;
    assign busy       = (state_q != ST_IDLE);
    assign pulse_count = pcnt_q;

    assign out_sum     = 32'(BASELINE) + 32'(lvl_q >> DECAY_SHIFT);
    assign sat         = (out_sum > ADC_MAX);
    assign output_data = sat ? {SIZE_ADC_DATA{1'b1}} : out_sum[SIZE_ADC_DATA-1:0];

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        cnt_d   = cnt_q;
        amp_d   = amp_q;
        pcnt_d  = pcnt_q;
        if (accept) begin
            state_d = ST_RISE;
            cnt_d   = '0;
            amp_d   = trig_amp;
            pcnt_d  = pcnt_q + 16'd1;
        end else if (enable) begin
            case (state_q)
                ST_RISE: begin
                    lvl_d = (rise_sum > LVL_MAX) ? LVL_MAX[LW-1:0] : rise_sum[LW-1:0];
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_d = ST_DECAY;
                    end
                end
                ST_DECAY: begin
                    if (decay_amt == '0) begin
                        lvl_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        lvl_d = lvl_q - decay_amt;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            lvl_q   <= '0;
            cnt_q   <= '0;
            amp_q   <= '0;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
            amp_q   <= amp_d;
            pcnt_q  <= pcnt_d;
        end
    end

endmodule

// File: tb/tb_v11_pulse_emulator.sv
// Bench for v11_pulse_emulator: integer pulse model compared every negedge, plus directed literal checks.
module tb_v11_pulse_emulator;

    localparam int ADC_W = 12;
    localparam int BASE  = 100;
    localparam int DS    = 4;
    localparam int RS    = 2;
    localparam int RISE_LEN = 1 << RS;
    localparam int ADC_MAX  = (1 << ADC_W) - 1;
    localparam int LMAX     = ADC_MAX << DS;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b1;
    logic             tv = 1'b0;
    logic [ADC_W-1:0] amp = '0;
    logic             ready;
    logic [ADC_W-1:0] out;
    logic             busy;
    logic             sat;
    logic [15:0]      pcnt;

    int nchecks = 0;
    int nerr = 0;
    bit chk_on = 1'b0;

    int m_lvl = 0;
    int m_base = 0;
    int m_k = 0;
    int m_amp = 0;
    int m_cnt = 0;
    bit m_rising = 1'b0;
    bit m_busy = 1'b0;

    int shp[5] = '{140, 180, 220, 260, 250};

    v11_pulse_emulator #(
        .SIZE_ADC_DATA(ADC_W),
        .BASELINE(BASE),
        .DECAY_SHIFT(DS),
        .RISE_SHIFT(RS)
    ) dut (
        .clk(clk),
        .reset(rst),
        .enable(en),
        .trig_valid(tv),
        .trig_amp(amp),
        .trig_ready(ready),
        .output_data(out),
        .busy(busy),
        .sat(sat),
        .pulse_count(pcnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Model: rise level is base + k*amp*2^(DS-RS) clipped; tail loses floor(lvl/2^DS) per clk.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lvl = 0; m_k = 0; m_cnt = 0; m_rising = 0; m_busy = 0;
        end else if (en) begin
            if (tv && !m_rising) begin
                m_cnt    = (m_cnt + 1) % 65536;
                m_amp    = int'(amp);
                m_base   = m_lvl;
                m_k      = 0;
                m_rising = 1;
                m_busy   = 1;
            end else if (m_rising) begin
                m_k++;
                m_lvl = imin(m_base + m_k * m_amp * (1 << (DS - RS)), LMAX);
                if (m_k == RISE_LEN) m_rising = 0;
            end else if (m_busy) begin
                if (m_lvl < (1 << DS)) begin
                    m_lvl  = 0;
                    m_busy = 0;
                end else begin
                    m_lvl = m_lvl - m_lvl / (1 << DS);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            int e;
            e = BASE + m_lvl / (1 << DS);
            check("model_out", int'(out), imin(e, ADC_MAX));
            check("model_sat", int'(sat), int'(e > ADC_MAX));
            check("model_busy", int'(busy), int'(m_busy));
            check("model_ready", int'(ready), int'(en && !m_rising));
            check("model_count", int'(pcnt), m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_shape(input string name);
        amp = 12'd160; tv = 1'b1;
        tick();
        tv = 1'b0;
        check({name, "_accept_out"}, int'(out), BASE);
        check({name, "_accept_rdy"}, int'(ready), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check({name, "_shape"}, int'(out), shp[i]);
            if (i < 3) check({name, "_rise_rdy"}, int'(ready), 0);
        end
    endtask

    task automatic wait_idle(input string name, input int budget, input bit mono);
        int n = 0;
        int prev = int'(out);
        while (busy && n < budget) begin
            tick();
            n++;
            if (mono) begin
                check({name, "_mono"}, int'(int'(out) > prev), 0);
                prev = int'(out);
            end
        end
        check({name, "_idle_busy"}, int'(busy), 0);
        check({name, "_idle_out"}, int'(out), BASE);
    endtask

    initial begin
        repeat (3) tick();
        chk_on = 1'b1;
        check("rst_out", int'(out), BASE);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(ready), 1);
        check("rst_count", int'(pcnt), 0);
        rst = 1'b0;
        repeat (20) tick();
        check("idle_out", int'(out), BASE);

        pulse_shape("single");
        wait_idle("single", 300, 1'b1);
        check("single_count", int'(pcnt), 1);

        pulse_shape("pile");
        amp = 12'd160; tv = 1'b1;
        tick();
        tv = 1'b0;
        check("pile_start", int'(out), 250);
        check("pile_count", int'(pcnt), 3);
        repeat (4) tick();
        check("pile_peak", int'(out), 410);
        wait_idle("pile", 300, 1'b1);

        amp = 12'd160; tv = 1'b1;
        repeat (6) tick();
        tv = 1'b0;
        check("hold_count", int'(pcnt), 5);
        check("hold_out", int'(out), 260);
        wait_idle("hold", 300, 1'b0);

        amp = 12'd0; tv = 1'b1;
        tick();
        tv = 1'b0;
        wait_idle("zero", 20, 1'b0);
        check("zero_count", int'(pcnt), 6);

        amp = 12'd4095; tv = 1'b1;
        tick();
        tv = 1'b0;
        repeat (3) tick();
        check("sat_pre_out", int'(out), 3171);
        check("sat_pre_sat", int'(sat), 0);
        tick();
        check("sat_peak_out", int'(out), 4095);
        check("sat_peak_sat", int'(sat), 1);
        tick();
        check("sat_decay_out", int'(out), 3939);
        check("sat_decay_sat", int'(sat), 0);
        wait_idle("sat", 400, 1'b1);

        pulse_shape("freeze");
        tick();
        tick();
        check("freeze_pre", int'(out), 231);
        en = 1'b0; tv = 1'b1; amp = 12'd300;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("freeze_out", int'(out), 231);
            check("freeze_ready", int'(ready), 0);
            check("freeze_count", int'(pcnt), 8);
        end
        en = 1'b1; tv = 1'b0;
        tick();
        check("freeze_resume", int'(out), 223);
        wait_idle("freeze", 300, 1'b1);

        amp = 12'd500; tv = 1'b1;
        tick();
        tv = 1'b0;
        repeat (4) tick();
        check("arst_peak", int'(out), 600);
        #2 rst = 1'b1;
        #1;
        check("arst_out", int'(out), BASE);
        check("arst_busy", int'(busy), 0);
        check("arst_count", int'(pcnt), 0);
        tick();
        rst = 1'b0;
        tick();
        pulse_shape("after_rst");
        check("after_rst_count", int'(pcnt), 1);
        wait_idle("after_rst", 300, 1'b1);

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
